// File: rtl/imem_read_arbiter.sv
// Two-port round-robin read arbiter for the single-ported instruction memory bank.
// Each transaction is a fixed IDLE/RESP -> ACCESS -> RESP sequence with a registered response.
module imem_read_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              valid0,
  output logic              valid1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0]   gaddr_q, gaddr_d;
  logic                valid0_q, valid0_d;
  logic                valid1_q, valid1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  logic                pick_vld, pick_port, pick_ok, gaddr_ok;
  logic [ADDR_W-1:0]   pick_addr;

  // Grant selection: in IDLE round-robin on a tie; in RESP only the other port may be picked.
  always_comb begin
    pick_vld  = 1'b0;
    pick_port = 1'b0;
    if (state_q == S_IDLE) begin
      if (req0 && req1) begin
        pick_vld  = 1'b1;
        pick_port = ~last_gnt_q;
      end else if (req0 || req1) begin
        pick_vld  = 1'b1;
        pick_port = req1;
      end
    end else if (state_q == S_RESP) begin
      if (!gnt_q && req1) begin
        pick_vld  = 1'b1;
        pick_port = 1'b1;
      end else if (gnt_q && req0) begin
        pick_vld  = 1'b1;
        pick_port = 1'b0;
      end
    end
    pick_addr = pick_port ? addr1 : addr0;
    pick_ok   = {1'b0, pick_addr} < DEPTH_C;
    gaddr_ok  = {1'b0, gaddr_q} < DEPTH_C;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    gaddr_d    = gaddr_q;
    valid0_d   = 1'b0;
    valid1_d   = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    busy_d     = 1'b0;
    mem_read_d = 1'b0;
    mem_addr_d = '0;
    case (state_q)
      S_ACCESS: begin
        rdata_d    = gaddr_ok ? mem_rdata : '0;
        err_d      = ~gaddr_ok;
        last_gnt_d = gnt_q;
        valid0_d   = ~gnt_q;
        valid1_d   = gnt_q;
        busy_d     = 1'b1;
        state_d    = S_RESP;
      end
      default: begin
        state_d = S_IDLE;
        if (pick_vld) begin
          // Bank port outputs are registered, so they are set up on entry to ACCESS.
          gnt_d      = pick_port;
          gaddr_d    = pick_addr;
          busy_d     = 1'b1;
          mem_read_d = pick_ok;
          mem_addr_d = pick_ok ? pick_addr : '0;
          state_d    = S_ACCESS;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      gaddr_q    <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      gaddr_q    <= gaddr_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign valid0   = valid0_q;
  assign valid1   = valid1_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign mem_read = mem_read_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_imem_read_arbiter.sv
// Directed bench for imem_read_arbiter; bank model returns mem[i] = i*10.
module tb_imem_read_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic              valid0, valid1, err, busy, mem_read;
  logic [DATA_W-1:0] rdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? (32'(mem_addr) * 32'd10) : 32'hDEADBEEF;

  imem_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .valid0(valid0), .valid1(valid1), .rdata(rdata), .err(err), .busy(busy),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  // Advance to the next falling edge and tally bank reads / overlapping valids.
  task automatic tick();
    @(negedge clk);
    if (mem_read) rd_cnt++;
    if (valid0 && valid1) both_cnt++;
  endtask

  task automatic wait_valid(input int port, output int lat);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if ((port == 0) ? valid0 : valid1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1; addr0 = 8'd2; req1 = 1'b1; addr1 = 8'd9;
    tick(); tick();
    checks++;
    if ({valid0, valid1, err, busy, mem_read} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {valid0, valid1, err, busy, mem_read});
    checks++;
    if (rdata !== '0 || mem_addr !== '0)
      $display("FAIL reset_data: got rdata=%0d mem_addr=%0d want 0 0", rdata, mem_addr);
    if (rdata !== '0 || mem_addr !== '0) errors++;
    if ({valid0, valid1, err, busy, mem_read} !== 5'b0) errors++;
    rst_n = 1'b1;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 8'd2) begin
      errors++;
      $display("FAIL reset_first_grant: got mem_read=%b mem_addr=%0d want 1 2", mem_read, mem_addr);
    end
    tick();
    checks++;
    if (valid0 !== 1'b1 || rdata !== 32'd20) begin
      errors++;
      $display("FAIL reset_first_resp: got valid0=%b rdata=%0d want 1 20", valid0, rdata);
    end
    req0 = 1'b0;
    tick();
    tick();
    checks++;
    if (valid1 !== 1'b1 || rdata !== 32'd90) begin
      errors++;
      $display("FAIL reset_second_resp: got valid1=%b rdata=%0d want 1 90", valid1, rdata);
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int exp_port[4] = '{0, 1, 0, 1};
    int got, last_c, port;
    logic p0, p1;
    got = 0; last_c = 0; p0 = 1'b0; p1 = 1'b0;
    rd_cnt = 0; both_cnt = 0;
    addr0 = 8'd3; addr1 = 8'd7; req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 20 && got < 4; c++) begin
      tick();
      if (p0) begin req0 = 1'b1; p0 = 1'b0; end
      if (p1) begin req1 = 1'b1; p1 = 1'b0; end
      if (valid0 || valid1) begin
        port = valid1 ? 1 : 0;
        checks++;
        if (port != exp_port[got]) begin
          errors++;
          $display("FAIL contention_order[%0d]: got port %0d want %0d", got, port, exp_port[got]);
        end
        checks++;
        if (rdata !== ((port == 1) ? 32'd70 : 32'd30) || err !== 1'b0) begin
          errors++;
          $display("FAIL contention_data[%0d]: got rdata=%0d err=%b want %0d 0", got, rdata, err,
                   (port == 1) ? 70 : 30);
        end
        checks++;
        if (c - last_c != 2) begin
          errors++;
          $display("FAIL contention_spacing[%0d]: got %0d cycles want 2", got, c - last_c);
        end
        last_c = c;
        if (port == 1) begin req1 = 1'b0; p1 = 1'b1; end
        else begin req0 = 1'b0; p0 = 1'b1; end
        got++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (got != 4 || rd_cnt != 4) begin
      errors++;
      $display("FAIL contention_count: got %0d valids %0d reads want 4 4", got, rd_cnt);
    end
    tick(); tick();
    checks++;
    if (both_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL contention_overlap: got both=%0d busy=%b want 0 0", both_cnt, busy);
    end
  endtask

  task automatic test_single();
    rd_cnt = 0;
    req0 = 1'b1; addr0 = 8'd5;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 8'd5 || valid0 !== 1'b0) begin
      errors++;
      $display("FAIL single_access: got mem_read=%b mem_addr=%0d valid0=%b want 1 5 0",
               mem_read, mem_addr, valid0);
    end
    tick();
    checks++;
    if (valid0 !== 1'b1 || rdata !== 32'd50 || err !== 1'b0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: got valid0=%b rdata=%0d err=%b mem_read=%b want 1 50 0 0",
               valid0, rdata, err, mem_read);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (valid0 !== 1'b0 || busy !== 1'b0 || rdata !== 32'd50 || rd_cnt != 1) begin
      errors++;
      $display("FAIL single_after: got valid0=%b busy=%b rdata=%0d reads=%0d want 0 0 50 1",
               valid0, busy, rdata, rd_cnt);
    end
  endtask

  task automatic test_tie_after_port0();
    int lat;
    req0 = 1'b1; addr0 = 8'd4; req1 = 1'b1; addr1 = 8'd6;
    tick();
    checks++;
    if (mem_addr !== 8'd6) begin
      errors++;
      $display("FAIL tie_grant: got mem_addr=%0d want 6", mem_addr);
    end
    wait_valid(1, lat);
    checks++;
    if (lat != 1 || rdata !== 32'd60) begin
      errors++;
      $display("FAIL tie_resp1: got lat=%0d rdata=%0d want 1 60", lat, rdata);
    end
    req1 = 1'b0;
    wait_valid(0, lat);
    checks++;
    if (lat != 2 || rdata !== 32'd40) begin
      errors++;
      $display("FAIL tie_resp0: got lat=%0d rdata=%0d want 2 40", lat, rdata);
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; addr0 = 8'd10;
    tick();
    req1 = 1'b1; addr1 = 8'd20;
    tick();
    checks++;
    if (valid0 !== 1'b1 || rdata !== 32'd100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_resp0: got valid0=%b rdata=%0d busy=%b want 1 100 1", valid0, rdata, busy);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 8'd20 || busy !== 1'b1 || valid0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_access1: got mem_read=%b mem_addr=%0d busy=%b valid0=%b want 1 20 1 0",
               mem_read, mem_addr, busy, valid0);
    end
    tick();
    checks++;
    if (valid1 !== 1'b1 || rdata !== 32'd200) begin
      errors++;
      $display("FAIL b2b_resp1: got valid1=%b rdata=%0d want 1 200", valid1, rdata);
    end
    req1 = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    rd_cnt = 0;
    req1 = 1'b1; addr1 = 8'd64;
    wait_valid(1, lat);
    checks++;
    if (lat != 2 || err !== 1'b1 || rdata !== '0 || rd_cnt != 0) begin
      errors++;
      $display("FAIL oor_64: got lat=%0d err=%b rdata=%0d reads=%0d want 2 1 0 0", lat, err, rdata, rd_cnt);
    end
    req1 = 1'b0;
    tick();
    checks++;
    if (err !== 1'b1 || valid1 !== 1'b0) begin
      errors++;
      $display("FAIL oor_hold: got err=%b valid1=%b want 1 0", err, valid1);
    end
    req1 = 1'b1; addr1 = 8'd63;
    wait_valid(1, lat);
    checks++;
    if (lat != 2 || err !== 1'b0 || rdata !== 32'd630 || rd_cnt != 1) begin
      errors++;
      $display("FAIL oor_63: got lat=%0d err=%b rdata=%0d reads=%0d want 2 0 630 1", lat, err, rdata, rd_cnt);
    end
    req1 = 1'b0;
    tick();
    req1 = 1'b1; addr1 = 8'd255;
    wait_valid(1, lat);
    checks++;
    if (err !== 1'b1 || rdata !== '0 || rd_cnt != 1) begin
      errors++;
      $display("FAIL oor_255: got err=%b rdata=%0d reads=%0d want 1 0 1", err, rdata, rd_cnt);
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, vcnt;
    vcnt = 0;
    req0 = 1'b1; addr0 = 8'd12;
    tick();
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL mid_access: got mem_read=%b want 1", mem_read);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got mem_read=%b busy=%b want 0 0", mem_read, busy);
    end
    req0 = 1'b0;
    tick();
    if (valid0 || valid1) vcnt++;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (valid0 || valid1 || busy) vcnt++;
    end
    checks++;
    if (vcnt != 0) begin
      errors++;
      $display("FAIL mid_no_valid: got %0d active cycles want 0", vcnt);
    end
    req0 = 1'b1; addr0 = 8'd12;
    wait_valid(0, lat);
    checks++;
    if (lat != 2 || rdata !== 32'd120 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reissue: got lat=%0d rdata=%0d err=%b want 2 120 0", lat, rdata, err);
    end
    req0 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_tie_after_port0();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL valid_overlap: got %0d cycles want 0", both_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
